// File: rtl/ixu_decode_if.sv
// ixu_decode_if: bundle-in / decoded-bundle-out handshake bus of the IXU decode stage
interface ixu_decode_if #(
  parameter int NUM_SLOTS = 2,
  parameter int XLEN = 32
);
  logic flush;
  logic in_valid;
  logic in_ready;
  logic [32*NUM_SLOTS-1:0] in_inst;
  logic [NUM_SLOTS-1:0] in_slot_en;
  logic out_valid;
  logic out_ready;
  logic [NUM_SLOTS-1:0] out_slot_en;
  logic [5*NUM_SLOTS-1:0] out_op;
  logic [NUM_SLOTS-1:0] out_is_imm;
  logic [5*NUM_SLOTS-1:0] out_rd;
  logic [5*NUM_SLOTS-1:0] out_rs1;
  logic [5*NUM_SLOTS-1:0] out_rs2;
  logic [XLEN*NUM_SLOTS-1:0] out_imm;
  logic [NUM_SLOTS-1:0] out_illegal;
  modport slave (
    input flush, in_valid, in_inst, in_slot_en, out_ready,
    output in_ready, out_valid, out_slot_en, out_op, out_is_imm, out_rd, out_rs1, out_rs2, out_imm, out_illegal
  );
  modport master (
    output flush, in_valid, in_inst, in_slot_en, out_ready,
    input in_ready, out_valid, out_slot_en, out_op, out_is_imm, out_rd, out_rs1, out_rs2, out_imm, out_illegal
  );
endinterface

// File: rtl/ixu_decode_stage.sv
// ixu_decode_stage: registered parallel RV32I ALU decode of a NUM_SLOTS bundle with valid/ready, flush and illegal counting
// Ports: clk, rst_n (sync active-low), bus (ixu_decode_if.slave: flush, in_* bundle side, out_* decoded side),
//        illegal_cnt (saturating count of accepted, enabled, illegal slots)
module ixu_decode_stage #(
  parameter int NUM_SLOTS = 2,
  parameter int XLEN = 32,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  ixu_decode_if.slave bus,
  output logic [CNT_W-1:0] illegal_cnt
);
  localparam logic [4:0] POISON = 5'h1F;
  typedef struct packed {
    logic [4:0] op;
    logic is_imm;
    logic [XLEN-1:0] imm;
    logic ill;
  } dec_t;
  function automatic logic [4:0] base_op(input logic [2:0] f3);
    case (f3)
      3'd0: return 5'd0;
      3'd1: return 5'd5;
      3'd2: return 5'd8;
      3'd3: return 5'd9;
      3'd4: return 5'd2;
      3'd5: return 5'd6;
      3'd6: return 5'd3;
      default: return 5'd4;
    endcase
  endfunction
  // SUB and SRA sit one above ADD and SRL, so funct7 bit 5 selects the alternate op
  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    logic [2:0] f3;
    logic [6:0] f7;
    logic sh;
    f3 = i[14:12];
    f7 = i[31:25];
    sh = f3 == 3'd1 || f3 == 3'd5;
    d.is_imm = i[6:0] == 7'h13;
    d.ill = i[6:0] == 7'h33 ? !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) :
            d.is_imm ? sh && !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5)) : 1'b1;
    d.op = d.ill ? POISON : base_op(f3) + 5'(f7[5] && (!d.is_imm || sh));
    d.imm = !d.is_imm || d.ill ? '0 : sh ? XLEN'(i[24:20]) : {{(XLEN-12){i[31]}}, i[31:20]};
    d.is_imm = d.is_imm && !d.ill;
    return d;
  endfunction
  dec_t dec [NUM_SLOTS];
  logic accept;
  logic [5*NUM_SLOTS-1:0] d_op, d_rd, d_rs1, d_rs2;
  logic [NUM_SLOTS-1:0] d_is_imm, d_ill;
  logic [XLEN*NUM_SLOTS-1:0] d_imm;
  logic [3:0] n_ill;
  logic [CNT_W+3:0] cnt_sum;
  logic [CNT_W-1:0] cnt_next;
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_dec
    assign dec[g] = decode(bus.in_inst[32*g +: 32]);
  end
  assign bus.in_ready = !bus.flush && (!bus.out_valid || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  always_comb begin
    d_op = '0;
    d_rd = '0;
    d_rs1 = '0;
    d_rs2 = '0;
    d_is_imm = '0;
    d_ill = '0;
    d_imm = '0;
    n_ill = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      d_op[5*s +: 5] = bus.in_slot_en[s] ? dec[s].op : POISON;
      d_is_imm[s] = bus.in_slot_en[s] && dec[s].is_imm;
      d_ill[s] = bus.in_slot_en[s] && dec[s].ill;
      d_imm[XLEN*s +: XLEN] = bus.in_slot_en[s] ? dec[s].imm : '0;
      d_rd[5*s +: 5] = bus.in_slot_en[s] ? bus.in_inst[32*s+7 +: 5] : '0;
      d_rs1[5*s +: 5] = bus.in_slot_en[s] ? bus.in_inst[32*s+15 +: 5] : '0;
      d_rs2[5*s +: 5] = bus.in_slot_en[s] ? bus.in_inst[32*s+20 +: 5] : '0;
      n_ill = n_ill + 4'(d_ill[s]);
    end
  end
  assign cnt_sum = (CNT_W+4)'(illegal_cnt) + (CNT_W+4)'(n_ill);
  assign cnt_next = cnt_sum > (CNT_W+4)'({CNT_W{1'b1}}) ? '1 : cnt_sum[CNT_W-1:0];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_slot_en <= '0;
      bus.out_op <= '0;
      bus.out_is_imm <= '0;
      bus.out_rd <= '0;
      bus.out_rs1 <= '0;
      bus.out_rs2 <= '0;
      bus.out_imm <= '0;
      bus.out_illegal <= '0;
      illegal_cnt <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_slot_en <= bus.in_slot_en;
      bus.out_op <= d_op;
      bus.out_is_imm <= d_is_imm;
      bus.out_rd <= d_rd;
      bus.out_rs1 <= d_rs1;
      bus.out_rs2 <= d_rs2;
      bus.out_imm <= d_imm;
      bus.out_illegal <= d_ill;
      illegal_cnt <= cnt_next;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ixu_decode_stage.sv
// tb_ixu_decode_stage: directed checks of the decode stage, plus a CNT_W=2 instance for counter saturation
module tb_ixu_decode_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] cnt;
  logic [1:0] cnt2;
  int n_cmp = 0;
  int n_fail = 0;
  ixu_decode_if #(.NUM_SLOTS(2), .XLEN(32)) b();
  ixu_decode_if #(.NUM_SLOTS(2), .XLEN(32)) b2();
  ixu_decode_stage #(.NUM_SLOTS(2), .XLEN(32), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(b), .illegal_cnt(cnt));
  ixu_decode_stage #(.NUM_SLOTS(2), .XLEN(32), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2), .illegal_cnt(cnt2));
  always #5 clk = ~clk;

  task automatic send(input logic [63:0] inst, input logic [1:0] en);
    b.in_inst = inst;
    b.in_slot_en = en;
    b.in_valid = 1'b1;
    @(posedge clk); #1;
    b.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    b.flush = 0; b.in_valid = 0; b.in_inst = '0; b.in_slot_en = '0; b.out_ready = 1;
    b2.flush = 0; b2.in_valid = 0; b2.in_inst = '0; b2.in_slot_en = '0; b2.out_ready = 1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    n_cmp++; if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", b.out_valid); end
    n_cmp++; if (cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %h want 0", cnt); end
    n_cmp++; if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", b.in_ready); end
    n_cmp++; if (b.out_op !== 10'h000) begin n_fail++; $display("FAIL reset_op got %h want 000", b.out_op); end
  endtask

  task automatic test_rtype;
    send({32'h402081B3, 32'h002081B3}, 2'b11);
    n_cmp++; if (b.out_valid !== 1'b1) begin n_fail++; $display("FAIL r_valid got %b want 1", b.out_valid); end
    n_cmp++; if (b.out_op !== 10'h020) begin n_fail++; $display("FAIL r_op got %h want 020", b.out_op); end
    n_cmp++; if (b.out_rd !== 10'h063) begin n_fail++; $display("FAIL r_rd got %h want 063", b.out_rd); end
    n_cmp++; if (b.out_rs1 !== 10'h021) begin n_fail++; $display("FAIL r_rs1 got %h want 021", b.out_rs1); end
    n_cmp++; if (b.out_rs2 !== 10'h042) begin n_fail++; $display("FAIL r_rs2 got %h want 042", b.out_rs2); end
    n_cmp++; if (b.out_is_imm !== 2'b00) begin n_fail++; $display("FAIL r_is_imm got %b want 00", b.out_is_imm); end
    n_cmp++; if (b.out_illegal !== 2'b00) begin n_fail++; $display("FAIL r_illegal got %b want 00", b.out_illegal); end
    n_cmp++; if (b.out_slot_en !== 2'b11) begin n_fail++; $display("FAIL r_slot_en got %b want 11", b.out_slot_en); end
    @(posedge clk); #1;
    n_cmp++; if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL r_drain got %b want 0", b.out_valid); end
  endtask

  task automatic test_itype;
    send({32'h4032D293, 32'hFFF00093}, 2'b11);
    n_cmp++; if (b.out_op !== 10'h0E0) begin n_fail++; $display("FAIL i_op got %h want 0e0", b.out_op); end
    n_cmp++; if (b.out_is_imm !== 2'b11) begin n_fail++; $display("FAIL i_is_imm got %b want 11", b.out_is_imm); end
    n_cmp++; if (b.out_imm !== 64'h00000003_FFFFFFFF) begin n_fail++; $display("FAIL i_imm got %h want 00000003ffffffff", b.out_imm); end
    n_cmp++; if (b.out_rd !== 10'h0A1) begin n_fail++; $display("FAIL i_rd got %h want 0a1", b.out_rd); end
    n_cmp++; if (b.out_rs1 !== 10'h0A0) begin n_fail++; $display("FAIL i_rs1 got %h want 0a0", b.out_rs1); end
    n_cmp++; if (b.out_rs2[9:5] !== 5'd3) begin n_fail++; $display("FAIL i_rs2 got %h want 03", b.out_rs2[9:5]); end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype2;
    send({32'h4020D1B3, 32'h0020C1B3}, 2'b11);
    n_cmp++; if (b.out_op !== 10'h0E2) begin n_fail++; $display("FAIL r2_op got %h want 0e2", b.out_op); end
    n_cmp++; if (b.out_imm !== 64'h0) begin n_fail++; $display("FAIL r2_imm got %h want 0", b.out_imm); end
    n_cmp++; if (b.out_is_imm !== 2'b00) begin n_fail++; $display("FAIL r2_is_imm got %b want 00", b.out_is_imm); end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal;
    send({32'h0000006F, 32'h00000000}, 2'b11);
    n_cmp++; if (b.out_op !== 10'h3FF) begin n_fail++; $display("FAIL ill_op got %h want 3ff", b.out_op); end
    n_cmp++; if (b.out_illegal !== 2'b11) begin n_fail++; $display("FAIL ill_vec got %b want 11", b.out_illegal); end
    n_cmp++; if (cnt !== 16'd2) begin n_fail++; $display("FAIL ill_cnt got %0d want 2", cnt); end
    send({32'h0000006F, 32'h00000000}, 2'b01);
    n_cmp++; if (b.out_op !== 10'h3FF) begin n_fail++; $display("FAIL ill_en_op got %h want 3ff", b.out_op); end
    n_cmp++; if (b.out_illegal !== 2'b01) begin n_fail++; $display("FAIL ill_en_vec got %b want 01", b.out_illegal); end
    n_cmp++; if (cnt !== 16'd3) begin n_fail++; $display("FAIL ill_en_cnt got %0d want 3", cnt); end
    send({32'h40009093, 32'h022081B3}, 2'b11);
    n_cmp++; if (b.out_illegal !== 2'b11) begin n_fail++; $display("FAIL ill_f7_vec got %b want 11", b.out_illegal); end
    n_cmp++; if (b.out_is_imm !== 2'b00) begin n_fail++; $display("FAIL ill_f7_is_imm got %b want 00", b.out_is_imm); end
    n_cmp++; if (b.out_imm !== 64'h0) begin n_fail++; $display("FAIL ill_f7_imm got %h want 0", b.out_imm); end
    n_cmp++; if (cnt !== 16'd5) begin n_fail++; $display("FAIL ill_f7_cnt got %0d want 5", cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    b.out_ready = 0;
    send({32'h402081B3, 32'h002081B3}, 2'b11);
    b.in_inst = {32'h4032D293, 32'hFFF00093};
    b.in_slot_en = 2'b11;
    b.in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (b.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want 0", k, b.in_ready); end
      n_cmp++; if (b.out_valid !== 1'b1 || b.out_op !== 10'h020) begin n_fail++; $display("FAIL bp_hold[%0d] got v=%b op=%h want v=1 op=020", k, b.out_valid, b.out_op); end
      @(posedge clk); #1;
    end
    b.out_ready = 1;
    #1;
    n_cmp++; if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got %b want 1", b.in_ready); end
    @(posedge clk); #1;
    b.in_valid = 0;
    n_cmp++; if (b.out_valid !== 1'b1 || b.out_op !== 10'h0E0) begin n_fail++; $display("FAIL b2b_next got v=%b op=%h want v=1 op=0e0", b.out_valid, b.out_op); end
    @(posedge clk); #1;
    n_cmp++; if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", b.out_valid); end
  endtask

  task automatic test_flush;
    b.out_ready = 0;
    send({32'h402081B3, 32'h002081B3}, 2'b11);
    b.flush = 1;
    b.in_inst = {32'h0000006F, 32'h00000000};
    b.in_slot_en = 2'b11;
    b.in_valid = 1;
    #1;
    n_cmp++; if (b.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %b want 0", b.in_ready); end
    @(posedge clk); #1;
    b.flush = 0;
    b.in_valid = 0;
    b.out_ready = 1;
    n_cmp++; if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", b.out_valid); end
    n_cmp++; if (cnt !== 16'd5) begin n_fail++; $display("FAIL flush_cnt got %0d want 5", cnt); end
  endtask

  task automatic test_reset_mid_hold;
    b.out_ready = 0;
    send({32'h4032D293, 32'hFFF00093}, 2'b11);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    b.out_ready = 1;
    n_cmp++; if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hold_valid got %b want 0", b.out_valid); end
    n_cmp++; if (b.out_imm !== 64'h0 || b.out_op !== 10'h0 || b.out_rd !== 10'h0 || b.out_is_imm !== 2'b00) begin n_fail++; $display("FAIL rst_hold_fields got imm=%h op=%h rd=%h want 0", b.out_imm, b.out_op, b.out_rd); end
    n_cmp++; if (cnt !== 16'd0) begin n_fail++; $display("FAIL rst_hold_cnt got %0d want 0", cnt); end
  endtask

  task automatic test_saturate;
    logic [1:0] want [3];
    want[0] = 2'd2; want[1] = 2'd3; want[2] = 2'd3;
    for (int k = 0; k < 3; k++) begin
      b2.in_inst = {32'h0000006F, 32'h00000000};
      b2.in_slot_en = 2'b11;
      b2.in_valid = 1;
      @(posedge clk); #1;
      b2.in_valid = 0;
      n_cmp++; if (cnt2 !== want[k]) begin n_fail++; $display("FAIL sat_cnt[%0d] got %0d want %0d", k, cnt2, want[k]); end
    end
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_itype;
    test_rtype2;
    test_illegal;
    test_back_to_back;
    test_flush;
    test_reset_mid_hold;
    test_saturate;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
